// File: rtl/dec24_stream_if.sv
// rtl/dec24_stream_if.sv - code-in / one-hot-out handshake bundle for dec24_stream
interface dec24_stream_if;
    logic in_valid;
    logic in_ready;
    logic f1;
    logic f0;
    logic out_valid;
    logic out_ready;
    logic a3;
    logic a2;
    logic a1;
    logic a0;

    modport master (
        output in_valid, f1, f0, out_ready,
        input  in_ready, out_valid, a3, a2, a1, a0
    );

    modport slave (
        input  in_valid, f1, f0, out_ready,
        output in_ready, out_valid, a3, a2, a1, a0
    );
endinterface

// File: rtl/dec24_stream.sv
// rtl/dec24_stream.sv - registered 2-to-4 decoder with skid buffer and saturating per-line hit counters
module dec24_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    dec24_stream_if.slave    s,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val,
    input  logic             clr_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state;
    logic [1:0]       out_code;
    logic [1:0]       skid;
    logic [3:0]       out_line;
    logic [CNT_W-1:0] cnt [4];

    logic [1:0] in_code;
    logic       accept;
    logic       pop;

    assign in_code     = {s.f1, s.f0};
    assign s.in_ready  = (state != FULL);
    assign s.out_valid = (state != EMPTY);
    assign {s.a3, s.a2, s.a1, s.a0} = out_line;
    assign accept      = s.in_valid & s.in_ready;
    assign pop         = s.out_valid & s.out_ready;

    function automatic logic [3:0] decode(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_code <= 2'b00;
            out_line <= 4'b0000;
            skid     <= 2'b00;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_code <= in_code;
                        out_line <= decode(in_code);
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_code <= in_code;
                        out_line <= decode(in_code);
                    end else if (accept) begin
                        skid  <= in_code;
                        state <= FULL;
                    end else if (pop) begin
                        // Keep the lines dark whenever nothing is presented.
                        out_line <= 4'b0000;
                        state    <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_code <= skid;
                        out_line <= decode(skid);
                        state    <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // cnt_val samples the counters before this edge's clear/increment lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_val <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            cnt_val <= cnt[cnt_sel];
            if (clr_cnt) begin
                for (int i = 0; i < 4; i++) cnt[i] <= '0;
            end else if (pop && (cnt[out_code] != {CNT_W{1'b1}})) begin
                cnt[out_code] <= cnt[out_code] + 1'b1;
            end
        end
    end

endmodule

// File: doc/dec24_stream.md
Name: dec24_stream

Overview:
- Registered 2-to-4 decoder: the receive-side counterpart of the 4-to-2 encoder.
- Takes a 2-bit code {f1,f0} and produces a one-hot line a3..a0.
- Code and one-hot line each move through a valid/ready handshake, buffered by a 2-entry skid buffer so in_ready has no combinational path from out_ready.
- Per-line saturating hit counters give verification and debug visibility of decoded traffic.

Parameters:
- CNT_W, 8, width of each per-line hit counter (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  f1,f0 hold a valid code
- in_ready  output  1  block can accept a code this cycle
- f1  input  1  code MSB
- f0  input  1  code LSB
- out_valid  output  1  a3..a0 hold a valid one-hot word
- out_ready  input  1  downstream accepts the word this cycle
- a3  output  1  one-hot line 3 (code 11)
- a2  output  1  one-hot line 2 (code 10)
- a1  output  1  one-hot line 1 (code 01)
- a0  output  1  one-hot line 0 (code 00)
- cnt_sel  input  2  selects which line counter is read
- cnt_val  output  CNT_W  registered value of the selected counter
- clr_cnt  input  1  synchronous clear of all four counters

Behaviour:
- Reset: one clk and one rst are used, and reset is synchronous and active-high. While rst is high at a rising clk edge, the block resets as follows:
  - state goes to EMPTY;
  - out_valid=0, in_ready=1, a3..a0=0000;
  - all counters=0, cnt_val=0;
  - the skid register goes to 00.
  - Reset mid-transfer discards both buffered entries; no handshake completes on the reset edge.
- Handshakes:
  - Accept occurs when in_valid&in_ready at a rising edge.
  - Pop occurs when out_valid&out_ready at a rising edge.
  - in_ready = (state != FULL), decoded from registered state only.
  - out_valid = (state != EMPTY).
  - While out_valid=1 and the word is not popped, a3..a0 must stay stable.
- Decode: code 00→a0, 01→a1, 10→a2, 11→a3.
  - Exactly one line is high while out_valid=1.
  - a3..a0=0000 while out_valid=0.
- Latency:
  - A code accepted in EMPTY at edge k appears on a3..a0 with out_valid=1 after edge k.
  - Minimum latency is 1 cycle.
  - Throughput is 1 word/cycle when out_ready is held high.
- FSM, 3 states:
  - EMPTY: on accept, the output register takes the decoded code and state goes to ONE.
  - ONE:
    - accept&pop: output register takes the new code; stay in ONE.
    - accept only: skid register takes the code; go to FULL.
    - pop only: go to EMPTY.
    - neither: hold.
  - FULL: in_ready=0, so no accept is possible.
    - pop: the skid code moves to the output register; go to ONE.
    - no pop: hold.
- Ordering: words leave in strict acceptance order. The skid buffer never reorders or drops a word.
- Counters:
  - On each pop, the counter of the popped line increments by 1.
  - Counters saturate at 2^CNT_W−1 and never wrap.
  - clr_cnt=1 forces all counters to 0 at the edge, and takes priority over a simultaneous pop increment.
- Counter read:
  - cnt_val is registered from counter[cnt_sel], 1-cycle latency.
  - The value returned is the counter as it stood before the current edge's update.
- in_valid is ignored while in_ready=0; f1,f0 are don't-care when not accepted.

Test Plan:
- Reset, then in_valid=1 for 4 cycles with codes 00,01,10,11 and out_ready=1 → a3..a0 = 0001,0010,0100,1000 on 4 consecutive cycles, each 1 cycle after accept; out_valid high throughout; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0; send codes 10 then 01.
  - Required: state FULL, in_ready=0; a third code (11) is presented and not accepted.
  - Then raise out_ready: outputs 0100, then 0010, then 1000, in that order; in_ready returns to 1 the cycle after the first pop.
- Saturation with CNT_W=2: pop code 11 five times, then read with cnt_sel=3 → cnt_val=3 (no wrap); the other selects read 0.
- Clear collision: clr_cnt=1 on the same edge as a pop of code 00 → counter 0 reads 0 on the next cnt_sel=0 read.
- Reset mid-operation: in FULL with codes 00,11 buffered, assert rst for 1 cycle → out_valid=0, a3..a0=0000, in_ready=1; both words lost; counters=0.
- Idle/stability:
  - Hold out_valid=1 with out_ready=0 for 10 cycles while toggling f1,f0 with in_valid=0 → a3..a0 stays unchanged.
  - With in_valid=0 and no buffered word → out_valid=0 and outputs 0000.
